// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool: raster-order pixels in, one pooled pixel per 2x2 window out.
// A pair register folds columns, a half-width line buffer folds rows, and a single output register holds the result.
module maxpool2x2_stream #(
  parameter int D          = 3,
  parameter int W          = 4,
  parameter int H          = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam int LN = W / 2;
  localparam int LW = (LN > 1) ? $clog2(LN) : 1;

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DW-1:0]         r_ch;
  logic [DATA_WIDTH-1:0] r_pair;
  logic [DATA_WIDTH-1:0] r_lb [LN];
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_valid;
  logic                  r_last;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_col_end;
  logic                  w_row_end;
  logic                  w_ch_end;
  logic                  w_load;
  logic [LW-1:0]         w_lb_idx;
  logic [DATA_WIDTH-1:0] w_lb_rd;
  logic [DATA_WIDTH-1:0] w_hmax;
  logic [DATA_WIDTH-1:0] w_vmax;

  assign in_ready   = ~r_valid | out_ready;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_valid & out_ready;

  assign w_col_end = (r_col == CW'(W - 1));
  assign w_row_end = (r_row == RW'(H - 1));
  assign w_ch_end  = (r_ch == DW'(D - 1));

  assign w_lb_idx = LW'(r_col >> 1);
  assign w_lb_rd  = r_lb[w_lb_idx];
  assign w_hmax   = ($signed(in_data) > $signed(r_pair)) ? in_data : r_pair;
  assign w_vmax   = ($signed(w_lb_rd) > $signed(w_hmax)) ? w_lb_rd : w_hmax;

  // Window completes on the odd-row, odd-col pixel.
  assign w_load = w_in_fire & r_col[0] & r_row[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_ch   <= '0;
      r_pair <= '0;
    end else if (w_in_fire) begin
      if (!r_col[0]) r_pair <= in_data;
      if (w_col_end) begin
        r_col <= '0;
        if (w_row_end) begin
          r_row <= '0;
          r_ch  <= w_ch_end ? '0 : r_ch + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Every entry is rewritten on an even row before the odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_in_fire && r_col[0] && !r_row[0]) r_lb[w_lb_idx] <= w_hmax;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_out   <= w_vmax;
      r_valid <= 1'b1;
      r_last  <= w_col_end & w_row_end & w_ch_end;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign out_data  = r_out;
  assign out_valid = r_valid;
  assign out_last  = r_last;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: four instances with different geometries, table vectors,
// hand-written stall/reset sequences and a randomized frame against a window-max model.
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst, iv, ordy, ir, ov, ol;
  logic [15:0] idat [4];
  logic [15:0] odat [4];

  maxpool2x2_stream #(.D(1), .W(4), .H(4), .DATA_WIDTH(16)) u_a (
    .clk(clk), .reset(rst[0]), .in_data(idat[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .out_data(odat[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_last(ol[0]));
  maxpool2x2_stream #(.D(1), .W(2), .H(2), .DATA_WIDTH(16)) u_b (
    .clk(clk), .reset(rst[1]), .in_data(idat[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .out_data(odat[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_last(ol[1]));
  maxpool2x2_stream #(.D(3), .W(4), .H(4), .DATA_WIDTH(16)) u_c (
    .clk(clk), .reset(rst[2]), .in_data(idat[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .out_data(odat[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_last(ol[2]));
  maxpool2x2_stream #(.D(2), .W(8), .H(6), .DATA_WIDTH(16)) u_r (
    .clk(clk), .reset(rst[3]), .in_data(idat[3]), .in_valid(iv[3]), .in_ready(ir[3]),
    .out_data(odat[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_last(ol[3]));

  typedef struct {
    int          k;
    logic [16:0] v;
  } obs_t;

  typedef struct {
    logic [15:0] a, b, c, d;
    logic [15:0] exp;
  } vec_t;

  obs_t        obs [$];
  logic [16:0] expq [$];
  int          n_chk = 0;
  int          n_pass = 0;

  // Record every output transfer, {last, data}; instance b is checked directly.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      if (k != 1 && ov[k] && ordy[k] && !rst[k]) obs.push_back('{k, {ol[k], odat[k]}});
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ready(input int k);
    if (k == 3) ordy[3] = ($urandom % 3) != 0;
  endtask

  task automatic push(input int k, input logic [15:0] d);
    bit ok;
    int n;
    n = 0;
    iv[k] = 1'b1;
    idat[k] = d;
    do begin
      rand_ready(k);
      @(negedge clk);
      ok = ir[k];
      step();
      n++;
    end while (!ok && n < 1000);
    if (!ok) check("push_timeout", 0, 1);
    iv[k] = 1'b0;
  endtask

  task automatic idle(input int k, input int n);
    iv[k] = 1'b0;
    repeat (n) begin
      rand_ready(k);
      step();
    end
  endtask

  task automatic cmp(input int k, input string nm);
    obs_t rest [$];
    int   got_n;
    got_n = 0;
    foreach (obs[i]) begin
      if (obs[i].k == k) begin
        if (got_n < expq.size()) check($sformatf("%s[%0d]", nm, got_n), obs[i].v, expq[got_n]);
        got_n++;
      end else begin
        rest.push_back(obs[i]);
      end
    end
    check({nm, "_count"}, got_n, expq.size());
    obs = rest;
    expq.delete();
  endtask

  function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  vec_t        tbl [7];
  logic [15:0] px [96];
  int          nv;
  logic        exp_v;

  initial begin
    tbl[0] = '{16'hFFFF, 16'h8000, 16'hFFFE, 16'h8001, 16'hFFFF};
    tbl[1] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    tbl[2] = '{16'h0000, 16'h7FFF, 16'h8000, 16'h0001, 16'h7FFF};
    tbl[3] = '{16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005};
    tbl[4] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 16'h0000};
    tbl[5] = '{16'h1234, 16'hFFFF, 16'h7FFE, 16'h7FFF, 16'h7FFF};
    tbl[6] = '{16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFF, 16'hFFFF};

    rst = 4'hF; iv = 4'h0; ordy = 4'hF;
    for (int k = 0; k < 4; k++) idat[k] = 16'h0;
    step(); step();
    rst = 4'h0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_valid%0d", k), ov[k], 0);
      check($sformatf("rst_data%0d", k), odat[k], 0);
      check($sformatf("rst_last%0d", k), ol[k], 0);
      check($sformatf("rst_ready%0d", k), ir[k], 1);
    end

    // Single plane, continuous stream: cycle-exact valid and latency.
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      iv[0] = 1'b1;
      idat[0] = 16'(i);
      step();
      exp_v = ((i / 4) % 2 == 1) && (i % 2 == 1);
      nv += int'(ov[0]);
      check($sformatf("t1_valid%0d", i), ov[0], exp_v);
      if (exp_v) begin
        check($sformatf("t1_data%0d", i), odat[0], i);
        check($sformatf("t1_last%0d", i), ol[0], i == 15);
      end
    end
    iv[0] = 1'b0;
    step();
    nv += int'(ov[0]);
    check("t1_valid_cycles", nv, 4);
    step();
    obs.delete();

    // Table-driven single-window vectors: signed compare and ties.
    for (int t = 0; t < 7; t++) begin
      push(1, tbl[t].a); push(1, tbl[t].b); push(1, tbl[t].c); push(1, tbl[t].d);
      check($sformatf("tbl_valid%0d", t), ov[1], 1);
      check($sformatf("tbl_data%0d", t), odat[1], tbl[t].exp);
      check($sformatf("tbl_last%0d", t), ol[1], 1);
    end

    // Multi-plane, two back-to-back frames.
    for (int fr = 0; fr < 2; fr++)
      for (int i = 0; i < 48; i++) push(2, 16'(i));
    idle(2, 3);
    for (int fr = 0; fr < 2; fr++)
      for (int ch = 0; ch < 3; ch++)
        for (int wr = 1; wr < 4; wr += 2)
          for (int wc = 1; wc < 4; wc += 2)
            expq.push_back({(ch == 2 && wr == 3 && wc == 3), 16'(ch * 16 + wr * 4 + wc)});
    cmp(2, "multi");

    // Backpressure on the first output.
    for (int i = 0; i < 6; i++) push(0, 16'(i));
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    idat[0] = 16'd6;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_in_ready", ir[0], 0);
      check("bp_valid", ov[0], 1);
      check("bp_data", odat[0], 5);
      step();
    end
    ordy[0] = 1'b1;
    for (int i = 6; i < 16; i++) push(0, 16'(i));
    idle(0, 3);
    expq.push_back({1'b0, 16'd5}); expq.push_back({1'b0, 16'd7});
    expq.push_back({1'b0, 16'd13}); expq.push_back({1'b1, 16'd15});
    cmp(0, "bp");

    // Reset mid-frame, then a clean restart.
    for (int i = 0; i < 6; i++) push(0, 16'(i));
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    check("mid_rst_valid", ov[0], 0);
    check("mid_rst_data", odat[0], 0);
    check("mid_rst_ready", ir[0], 1);
    obs.delete();
    for (int i = 0; i < 16; i++) push(0, 16'(i));
    idle(0, 3);
    expq.push_back({1'b0, 16'd5}); expq.push_back({1'b0, 16'd7});
    expq.push_back({1'b0, 16'd13}); expq.push_back({1'b1, 16'd15});
    cmp(0, "rst");

    // Random frame with random gaps and backpressure against a window-max model.
    for (int i = 0; i < 96; i++) begin
      case ($urandom % 8)
        0:       px[i] = 16'h8000;
        1:       px[i] = 16'h7FFF;
        default: px[i] = 16'($urandom);
      endcase
    end
    for (int i = 0; i < 96; i++) begin
      idle(3, $urandom % 3);
      push(3, px[i]);
    end
    idle(3, 200);
    ordy[3] = 1'b1;
    idle(3, 3);
    for (int c = 0; c < 2; c++)
      for (int r2 = 0; r2 < 3; r2++)
        for (int c2 = 0; c2 < 4; c2++) begin
          logic [15:0] m;
          int base;
          base = (c * 6 + 2 * r2) * 8 + 2 * c2;
          m = smax(smax(px[base], px[base + 1]), smax(px[base + 8], px[base + 9]));
          expq.push_back({(c == 1 && r2 == 2 && c2 == 3), m});
        end
    cmp(3, "rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_stream.md
# maxpool2x2_stream

Streaming 2x2 stride-2 max-pool downsampler: the inverse-direction companion of the 2x nearest-neighbour upsampler in the neck. Accepts D feature planes of W x H signed fixed-point pixels in raster order, one pixel per handshake, and emits D planes of (W/2) x (H/2) pixels, each the signed maximum of its 2x2 input window. Sits between a conv layer's output stream and the next stage (stride-2 reduction in the PAN path).

## Interface
- D, 3: number of channel planes per frame, processed sequentially.
- W, 4: input plane width in pixels; even, >= 2.
- H, 4: input plane height in pixels; even, >= 2.
- DATA_WIDTH, 16: pixel width, two's-complement signed.
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  input pixel.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  DATA_WIDTH  pooled pixel.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  qualifies out_valid: last pooled pixel of last plane of the frame.

## Operation
- Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Counters: col (0..W-1), row (0..H-1), ch (0..D-1); advance on each input transfer; col wraps to 0 and increments row; row wraps to 0 and increments ch; ch wraps to 0 (next frame, no gap).
- Pair register: on even col, store pixel in pair_reg. On odd col, hmax = signed max(pair_reg, in_data).
- Line buffer: W/2 entries x DATA_WIDTH, indexed col>>1. Even row, odd col: write hmax to line_buf[col>>1]. Odd row, odd col: result = signed max(line_buf[col>>1], hmax) loaded into output register.
- Ties: equal values give that value (no ordering visible).
- Comparisons strictly signed: 16'h8000 (-32768) < 16'h0000 < 16'h7FFF.
- out_last set with output register load when row==H-1, col==W-1, ch==D-1; cleared otherwise.
- in_ready = ~out_valid | out_ready (single output register; stall on any input while output held, simple and sufficient).
- Output register: out_valid set on load, cleared on output transfer without simultaneous load; simultaneous transfer and load keeps out_valid=1 with new data.
- Line buffer contents not cleared between planes/frames; every entry rewritten on even row before being read.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, in_ready=1 (combinational from out_valid=0); col=row=ch=0, pair_reg=0.
- Latency: out_valid asserts the cycle after the transfer of the odd-row, odd-col input pixel.
- Throughput: one input pixel per cycle with out_ready held high; one output per four inputs.
- out_data/out_last held stable while out_valid & ~out_ready.
- Reset mid-frame: all counters and output register cleared in the same cycle; partially accumulated window discarded; next accepted pixel is (ch0,row0,col0).
- in_valid low: no state change; counters hold.

## Test plan
- Single plane, D=1, W=H=4, inputs 0..15 raster, out_ready=1 -> outputs 5, 7, 13, 15; out_last only on 15; out_valid exactly 4 cycles high.
- Signed check, D=1, W=H=2, inputs 16'hFFFF, 16'h8000, 16'hFFFE, 16'h8001 -> output 16'hFFFF (-1); second window all 16'h8000 -> 16'h8000.
- Multi-plane, D=3, W=H=4, plane k = (0..15)+16k -> 12 outputs 5,7,13,15,21,23,29,31,37,39,45,47; out_last only on 47; back-to-back frame repeats identically.
- Backpressure: hold out_ready=0 for 10 cycles at first output of test 1 -> in_ready=0 during hold, out_data stays 5, no input lost; after release outputs 7,13,15 unchanged.
- Reset mid-frame: after 6 pixels of test 1 assert reset one cycle -> out_valid=0 next cycle; restart full 16-pixel sequence -> outputs 5,7,13,15 exactly.
- Random: D=2, W=8, H=6, random signed data, random in_valid/out_ready -> output stream matches golden 2x2 max model, count 24, one out_last.
